replay_csr_bank: RTL and testbench

REPLAY_CSR_BANK -- requirements
Module: replay_csr_bank

---
 rtl/replay_csr_bank_if.sv | 23 ++
 rtl/replay_csr_bank.sv | 187 ++++++++++++++++++
 tb/tb_replay_csr_bank.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/replay_csr_bank_if.sv
// replay_csr_bank_if: request/acknowledge register bus between a requester and the CSR bank.
// Latency: none (wires only); timing is set by the bank.
// Backpressure: none; the requester waits for reg_ack_out before presenting the next access.
interface replay_csr_bank_if #(
  parameter int AXI_ADDR_WIDTH = 26
);
  logic                      reg_req_in;
  logic                      reg_rd_wr_L_in;
  logic [AXI_ADDR_WIDTH-1:0] reg_addr_in;
  logic [31:0]               reg_wr_data;
  logic                      reg_ack_out;
  logic [31:0]               reg_rd_data;

  modport master (
    output reg_req_in, reg_rd_wr_L_in, reg_addr_in, reg_wr_data,
    input  reg_ack_out, reg_rd_data
  );

  modport slave (
    input  reg_req_in, reg_rd_wr_L_in, reg_addr_in, reg_wr_data,
    output reg_ack_out, reg_rd_data
  );
endinterface

// File: rtl/replay_csr_bank.sv
// replay_csr_bank: control registers plus per-channel done status (sticky/live) and event counters.
// Latency: request accepted in cycle N is acked in N+1 with registered read data; writes land at the same edge.
// Backpressure: none; one access in flight, a request seen during the ack cycle is ignored.
// Build option REPLAY_CSR_IRQ_EN: adds the IRQ mask register at index 0x2F and a registered irq_out.
module replay_csr_bank #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 26,
  parameter int REG_ADDR_WIDTH = 6,
  parameter logic [AXI_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] BLOCK_ADDR = 20'h10017,
  parameter int NUM_RW_REGS = 4,
  parameter int NUM_CH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_L,
  replay_csr_bank_if.slave         bus,
  output logic [32*NUM_RW_REGS-1:0] rw_regs,
  input  logic [NUM_CH-1:0]        done_in
`ifdef REPLAY_CSR_IRQ_EN
  ,
  output logic                     irq_out
`endif
);

  localparam int TAG_W = AXI_ADDR_WIDTH - REG_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [AXI_DATA_WIDTH-1:0] UNMAPPED = 32'hDEADBEEF;

  // Request decode
  logic [TAG_W-1:0] tag;
  logic [31:0]      idx;
  logic             accept;
  logic             wr_en;
  logic             rd_en;

  // Architectural state
  logic                      ack_q;
  logic [AXI_DATA_WIDTH-1:0] rd_q;
  logic [AXI_DATA_WIDTH-1:0] rw_q [NUM_RW_REGS];
  logic [NUM_CH-1:0]         done_q;
  logic [NUM_CH-1:0]         sticky_q;
  logic [CNT_WIDTH-1:0]      cnt_q [NUM_CH];

  // Per-target hit vectors and read mux output
  logic [NUM_RW_REGS-1:0]    ctrl_hit;
  logic [NUM_CH-1:0]         st_hit;
  logic [NUM_CH-1:0]         cnt_hit;
  logic [AXI_DATA_WIDTH-1:0] rd_next;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] st_clr;
  logic [NUM_CH-1:0] cnt_clr;

`ifdef REPLAY_CSR_IRQ_EN
  logic              mask_hit;
  logic [NUM_CH-1:0] mask_q;
  logic              irq_q;
`endif

  assign tag = bus.reg_addr_in[AXI_ADDR_WIDTH-1:REG_ADDR_WIDTH];
  assign idx = 32'(bus.reg_addr_in[REG_ADDR_WIDTH-1:0]);

  // Only one access in flight: the ack cycle itself never accepts.
  assign accept = bus.reg_req_in && (tag == BLOCK_ADDR) && !ack_q;
  assign wr_en  = accept && !bus.reg_rd_wr_L_in;
  assign rd_en  = accept &&  bus.reg_rd_wr_L_in;

  // A level change 0->1 between consecutive samples counts as one event.
  assign rise    = done_in & ~done_q;
  assign st_clr  = (wr_en && bus.reg_wr_data[0]) ? st_hit : '0;
  assign cnt_clr = wr_en ? cnt_hit : '0;

  // Index decode and read mux; anything that does not hit a target reads the poison pattern.
  always_comb begin
    ctrl_hit = '0;
    st_hit   = '0;
    cnt_hit  = '0;
    rd_next  = UNMAPPED;
`ifdef REPLAY_CSR_IRQ_EN
    mask_hit = 1'b0;
`endif
    for (int i = 0; i < NUM_RW_REGS; i++) begin
      if (idx == 32'(i)) begin
        ctrl_hit[i] = 1'b1;
        rd_next     = rw_q[i];
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx == 32'h20 + 32'(c)) begin
        st_hit[c] = 1'b1;
        rd_next   = {30'd0, done_in[c], sticky_q[c]};
      end
      if (idx == 32'h30 + 32'(c)) begin
        cnt_hit[c] = 1'b1;
        rd_next    = AXI_DATA_WIDTH'(cnt_q[c]);
      end
    end
`ifdef REPLAY_CSR_IRQ_EN
    if (idx == 32'h2F) begin
      mask_hit = 1'b1;
      rd_next  = AXI_DATA_WIDTH'(mask_q);
    end
`endif
  end

  // Acknowledge and read-data register; read data only moves on an accepted read.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ack_q <= 1'b0;
      rd_q  <= '0;
    end else begin
      ack_q <= accept;
      if (rd_en) begin
        rd_q <= rd_next;
      end
    end
  end

  // Control registers, written in place on an accepted write.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        rw_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RW_REGS; i++) begin
        if (wr_en && ctrl_hit[i]) begin
          rw_q[i] <= bus.reg_wr_data;
        end
      end
    end
  end

  // Edge history and sticky status; a same-cycle edge wins over the W1C clear.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      done_q   <= '0;
      sticky_q <= '0;
    end else begin
      done_q   <= done_in;
      sticky_q <= (sticky_q & ~st_clr) | rise;
    end
  end

  // Saturating event counters; a clear coinciding with an edge leaves the count at one.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt_clr[c]) begin
          cnt_q[c] <= rise[c] ? CNT_ONE : '0;
        end else if (rise[c] && (cnt_q[c] != CNT_MAX)) begin
          cnt_q[c] <= cnt_q[c] + CNT_ONE;
        end
      end
    end
  end

`ifdef REPLAY_CSR_IRQ_EN
  // Mask register and interrupt; irq follows sticky/mask one cycle later.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_en && mask_hit) begin
        mask_q <= bus.reg_wr_data[NUM_CH-1:0];
      end
      irq_q <= |(sticky_q & mask_q);
    end
  end

  assign irq_out = irq_q;
`endif

  assign bus.reg_ack_out = ack_q;
  assign bus.reg_rd_data = rd_q;

  for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_rw_out
    assign rw_regs[32*g +: 32] = rw_q[g];
  end

endmodule

// File: tb/tb_replay_csr_bank.sv
// tb_replay_csr_bank: directed scenarios plus random traffic checked against a behavioural model.
// Latency: model predicts ack/read data one clock after each request.
// Backpressure: requester re-presents only after deasserting for a cycle (directed) or at random.
module tb_replay_csr_bank;
  localparam int AW   = 26;
  localparam int RW   = 6;
  localparam int NRW  = 4;
  localparam int NCH  = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [19:0] TAG  = 20'h10017;
  localparam logic [19:0] MISS = 20'h10018;

  logic clk = 1'b0;
  logic reset_L = 1'b1;
  logic [NCH-1:0] done_v = '0;
  logic [32*NRW-1:0] rw_regs;
`ifdef REPLAY_CSR_IRQ_EN
  logic irq_out;
`endif

  replay_csr_bank_if #(.AXI_ADDR_WIDTH(AW)) bus ();

  replay_csr_bank #(
    .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RW),
    .BLOCK_ADDR(TAG), .NUM_RW_REGS(NRW), .NUM_CH(NCH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .bus(bus),
    .rw_regs(rw_regs),
    .done_in(done_v)
`ifdef REPLAY_CSR_IRQ_EN
    ,
    .irq_out(irq_out)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model state
  logic [31:0]    rw_m [NRW];
  logic [NCH-1:0] sticky_m;
  logic [NCH-1:0] prev_m;
  logic [NCH-1:0] mask_m;
  int             cnt_m [NCH];
  logic           ack_m;
  logic [31:0]    rd_m;
  logic           irq_m;

  task automatic model_reset();
    for (int i = 0; i < NRW; i++) rw_m[i] = '0;
    for (int c = 0; c < NCH; c++) cnt_m[c] = 0;
    sticky_m = '0;
    prev_m   = '0;
    mask_m   = '0;
    ack_m    = 1'b0;
    rd_m     = '0;
    irq_m    = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input int idx);
    logic [31:0] v;
    v = 32'hDEADBEEF;
    if (idx < NRW) v = rw_m[idx];
    else if (idx >= 'h20 && idx < 'h20 + NCH) v = {30'd0, done_v[idx-'h20], sticky_m[idx-'h20]};
    else if (idx >= 'h30 && idx < 'h30 + NCH) v = 32'(cnt_m[idx-'h30]);
`ifdef REPLAY_CSR_IRQ_EN
    if (idx == 'h2F) v = 32'(mask_m);
`endif
    return v;
  endfunction

  function automatic logic [32*NRW-1:0] model_rw();
    logic [32*NRW-1:0] p;
    for (int i = 0; i < NRW; i++) p[32*i +: 32] = rw_m[i];
    return p;
  endfunction

  // Advance the model by one clock from the inputs currently driven, clock the DUT, compare.
  task automatic step();
    int          idx;
    logic        acc;
    logic [31:0] rv;
    logic [31:0] wd;
    logic        irq_next;
    idx = int'(bus.reg_addr_in[RW-1:0]);
    wd  = bus.reg_wr_data;
    acc = bus.reg_req_in && (bus.reg_addr_in[AW-1:RW] == TAG) && !ack_m;
    rv  = model_read(idx);
    irq_next = |(sticky_m & mask_m);
    if (acc && !bus.reg_rd_wr_L_in) begin
      if (idx < NRW) rw_m[idx] = wd;
      else if (idx >= 'h20 && idx < 'h20 + NCH) begin
        if (wd[0]) sticky_m[idx-'h20] = 1'b0;
      end else if (idx >= 'h30 && idx < 'h30 + NCH) cnt_m[idx-'h30] = 0;
`ifdef REPLAY_CSR_IRQ_EN
      if (idx == 'h2F) mask_m = wd[NCH-1:0];
`endif
    end
    for (int c = 0; c < NCH; c++) begin
      if (done_v[c] && !prev_m[c]) begin
        sticky_m[c] = 1'b1;
        if (cnt_m[c] < CMAX) cnt_m[c]++;
      end
    end
    prev_m = done_v;
    ack_m  = acc;
    if (acc && bus.reg_rd_wr_L_in) rd_m = rv;
    irq_m  = irq_next;
    @(posedge clk);
    #1;
    check("ack", bus.reg_ack_out, ack_m);
    check("rd_data", bus.reg_rd_data, rd_m);
    check("rw_regs", rw_regs, model_rw());
`ifdef REPLAY_CSR_IRQ_EN
    check("irq", irq_out, irq_m);
`endif
  endtask

  // One request cycle followed by one idle cycle; returns the ack seen after the request.
  task automatic access(input logic rd, input logic [19:0] tg, input int idx,
                        input logic [31:0] wd, output logic ack_seen);
    bus.reg_req_in     = 1'b1;
    bus.reg_rd_wr_L_in = rd;
    bus.reg_addr_in    = {tg, 6'(idx)};
    bus.reg_wr_data    = wd;
    step();
    ack_seen = bus.reg_ack_out;
    bus.reg_req_in = 1'b0;
    step();
  endtask

  task automatic pulse(input int c);
    done_v[c] = 1'b1;
    step();
    done_v[c] = 1'b0;
    step();
  endtask

  initial begin
    logic       a;
    logic [2:0] acks;
    logic [19:0] tg;
    int ix;
    bus.reg_req_in     = 1'b0;
    bus.reg_rd_wr_L_in = 1'b0;
    bus.reg_addr_in    = '0;
    bus.reg_wr_data    = '0;
    model_reset();
    #1 reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", bus.reg_ack_out, 1'b0);
    check("rst_rd", bus.reg_rd_data, 32'd0);
    check("rst_rw", rw_regs, '0);
    reset_L = 1'b1;
    step();

    // Control register write then read-back
    access(1'b0, TAG, 2, 32'hA5A5_0001, a);
    check("ctl_wr_ack", a, 1'b1);
    access(1'b1, TAG, 2, 32'h0, a);
    check("ctl_rd_ack", a, 1'b1);
    check("ctl_rd", bus.reg_rd_data, 32'hA5A5_0001);
    check("ctl_rw2", rw_regs[95:64], 32'hA5A5_0001);

    // Request held through the ack cycle is ignored, then re-accepted
    bus.reg_req_in = 1'b1;
    bus.reg_rd_wr_L_in = 1'b1;
    bus.reg_addr_in = {TAG, 6'd2};
    for (int k = 0; k < 3; k++) begin
      step();
      acks[k] = bus.reg_ack_out;
    end
    bus.reg_req_in = 1'b0;
    step();
    check("held_req_acks", acks, 3'b101);

    // Edge counting, sticky status and W1C
    repeat (3) pulse(1);
    access(1'b1, TAG, 'h31, 32'h0, a);
    check("cnt1_rd", bus.reg_rd_data, 32'd3);
    access(1'b1, TAG, 'h21, 32'h0, a);
    check("st1_set", bus.reg_rd_data, 32'h1);
    access(1'b0, TAG, 'h21, 32'h1, a);
    access(1'b1, TAG, 'h21, 32'h0, a);
    check("st1_w1c", bus.reg_rd_data, 32'h0);

    // Saturation and clear racing an edge
    repeat (17) pulse(0);
    access(1'b1, TAG, 'h30, 32'h0, a);
    check("cnt0_sat", bus.reg_rd_data, 32'hF);
    done_v[0] = 1'b1;
    access(1'b0, TAG, 'h30, 32'h0, a);
    done_v[0] = 1'b0;
    access(1'b1, TAG, 'h30, 32'h0, a);
    check("cnt0_clr_edge", bus.reg_rd_data, 32'h1);

    // Out-of-range index and tag miss
    access(1'b1, TAG, 'h10, 32'h0, a);
    check("oor_ack", a, 1'b1);
    check("oor_rd", bus.reg_rd_data, 32'hDEADBEEF);
    access(1'b1, MISS, 2, 32'h0, a);
    check("miss_ack", a, 1'b0);
    check("miss_rd_hold", bus.reg_rd_data, 32'hDEADBEEF);
    access(1'b0, MISS, 2, 32'h1234_5678, a);
    check("miss_wr_rw2", rw_regs[95:64], 32'hA5A5_0001);

`ifdef REPLAY_CSR_IRQ_EN
    access(1'b0, TAG, 'h2F, 32'h2, a);
    done_v[1] = 1'b1;
    step();
    check("irq_lag", irq_out, 1'b0);
    step();
    check("irq_set", irq_out, 1'b1);
    done_v[1] = 1'b0;
    access(1'b0, TAG, 'h21, 32'h1, a);
    check("irq_clr", irq_out, 1'b0);
`endif

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      bus.reg_req_in     = 1'($urandom_range(0, 1));
      bus.reg_rd_wr_L_in = 1'($urandom_range(0, 1));
      tg = ($urandom_range(0, 9) == 0) ? MISS : TAG;
      ix = int'($urandom_range(0, 63));
      bus.reg_addr_in = {tg, 6'(ix)};
      bus.reg_wr_data = $urandom;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) done_v[c] = ~done_v[c];
      end
      step();
    end
    bus.reg_req_in = 1'b0;
    done_v = '0;
    step();

    // Reset asserted mid-request
    pulse(0);
    access(1'b0, TAG, 1, 32'hCAFE_0000, a);
    access(1'b1, TAG, 1, 32'h0, a);
    bus.reg_req_in = 1'b1;
    bus.reg_rd_wr_L_in = 1'b1;
    bus.reg_addr_in = {TAG, 6'd1};
    #2 reset_L = 1'b0;
    #1;
    check("arst_ack", bus.reg_ack_out, 1'b0);
    check("arst_rd", bus.reg_rd_data, 32'd0);
    check("arst_rw", rw_regs, '0);
    @(posedge clk);
    #1;
    check("arst_no_ack", bus.reg_ack_out, 1'b0);
    bus.reg_req_in = 1'b0;
    model_reset();
    reset_L = 1'b1;
    step();
    access(1'b1, TAG, 'h30, 32'h0, a);
    check("post_rst_cnt0", bus.reg_rd_data, 32'd0);
    access(1'b1, TAG, 'h31, 32'h0, a);
    check("post_rst_cnt1", bus.reg_rd_data, 32'd0);
    access(1'b1, TAG, 'h20, 32'h0, a);
    check("post_rst_st0", bus.reg_rd_data, 32'd0);
    access(1'b1, TAG, 1, 32'h0, a);
    check("post_rst_ctl1", bus.reg_rd_data, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
